// File: rtl/dp_ram_fifo_ctrl_if.sv
// Bundle between the FIFO controller, its producer/consumer and the dp_ram ports.
// The slave modport is the controller's view; master is the surrounding environment.
interface dp_ram_fifo_ctrl_if #(
  parameter int add_wd  = 4,
  parameter int data_wd = 32
);
  logic               push;
  logic [data_wd-1:0] push_data;
  logic               full;
  logic               pop;
  logic               empty;
  logic [data_wd-1:0] pop_data;
  logic               pop_valid;
  logic [add_wd:0]    count;
  logic               overflow;
  logic               underflow;
  logic               ram_cs;
  logic               ram_rd;
  logic               ram_wr;
  logic [add_wd-1:0]  ram_rd_add;
  logic [add_wd-1:0]  ram_wr_add;
  logic [data_wd-1:0] ram_wr_data;
  logic [data_wd-1:0] ram_rd_data;

  modport slave (
    input  push, push_data, pop, ram_rd_data,
    output full, empty, pop_data, pop_valid, count, overflow, underflow,
           ram_cs, ram_rd, ram_wr, ram_rd_add, ram_wr_add, ram_wr_data
  );

  modport master (
    output push, push_data, pop, ram_rd_data,
    input  full, empty, pop_data, pop_valid, count, overflow, underflow,
           ram_cs, ram_rd, ram_wr, ram_rd_add, ram_wr_add, ram_wr_data
  );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// Synchronous FIFO controller driving a dp_ram on both ports; it absorbs the
// RAM's one-edge read latency and presents each popped word with a valid strobe.
module dp_ram_fifo_ctrl #(
  parameter int add_wd  = 4,
  parameter int data_wd = 32,
  parameter int depth   = 16
) (
  input logic               clk,
  input logic               rst,
  dp_ram_fifo_ctrl_if.slave bus
);
  localparam logic [add_wd:0]   depth_c    = (add_wd+1)'(depth);
  localparam logic [add_wd:0]   cnt_zero_c = {(add_wd+1){1'b0}};
  localparam logic [add_wd:0]   cnt_one_c  = {{add_wd{1'b0}}, 1'b1};
  localparam logic [add_wd-1:0] ptr_zero_c = {add_wd{1'b0}};
  localparam logic [add_wd-1:0] ptr_one_c  = {{(add_wd-1){1'b0}}, 1'b1};

  logic [add_wd-1:0]  wr_ptr_r;
  logic [add_wd-1:0]  rd_ptr_r;
  logic [add_wd:0]    count_r;
  logic               rd_pend_r;
  logic               pop_valid_r;
  logic [data_wd-1:0] pop_data_r;
  logic               overflow_r;
  logic               underflow_r;

  logic               full_s;
  logic               empty_s;
  logic               push_acc_s;
  logic               pop_acc_s;
  logic [add_wd:0]    count_nxt_s;

  // Acceptance decode from registered occupancy
  always_comb begin
    full_s     = (count_r == depth_c);
    empty_s    = (count_r == cnt_zero_c);
    push_acc_s = bus.push & ~full_s;
    pop_acc_s  = bus.pop & ~empty_s;
  end

  // Next occupancy; simultaneous accepted push and pop leave it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_acc_s, pop_acc_s})
      2'b10:   count_nxt_s = count_r + cnt_one_c;
      2'b01:   count_nxt_s = count_r - cnt_one_c;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and sticky error flags; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= ptr_zero_c;
      rd_ptr_r    <= ptr_zero_c;
      count_r     <= cnt_zero_c;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_one_c;
      end
      if (pop_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_one_c;
      end
      count_r <= count_nxt_s;
      if (bus.push && full_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.pop && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Read pipeline: the RAM answers one edge after the command, so capture then
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r   <= 1'b0;
      pop_valid_r <= 1'b0;
      pop_data_r  <= {data_wd{1'b0}};
    end else begin
      rd_pend_r   <= pop_acc_s;
      pop_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        pop_data_r <= bus.ram_rd_data;
      end
    end
  end

  assign bus.full        = full_s;
  assign bus.empty       = empty_s;
  assign bus.count       = count_r;
  assign bus.pop_data    = pop_data_r;
  assign bus.pop_valid   = pop_valid_r;
  assign bus.overflow    = overflow_r;
  assign bus.underflow   = underflow_r;
  assign bus.ram_cs      = push_acc_s | pop_acc_s;
  assign bus.ram_wr      = push_acc_s;
  assign bus.ram_rd      = pop_acc_s;
  assign bus.ram_wr_add  = wr_ptr_r;
  assign bus.ram_rd_add  = rd_ptr_r;
  assign bus.ram_wr_data = bus.push_data;
endmodule
